// File: rtl/operand_stage.sv
// Operand capture stage between decode and the ALU. It resolves rs1 and rs2 through the EX and WB
// bypasses, then holds up to two resolved entries in an output register and a skid register.
module operand_stage #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_rs1_addr,
   input  logic [4:0]        in_rs2_addr,
   input  logic [DATA_W-1:0] in_rs1_data,
   input  logic [DATA_W-1:0] in_rs2_data,
   input  logic [DATA_W-1:0] in_imm,
   input  logic              in_use_imm,
   input  logic [OP_W-1:0]   in_alu_op,
   input  logic [4:0]        in_rd_addr,
   input  logic              in_rd_we,
   input  logic              fwd_ex_we,
   input  logic [4:0]        fwd_ex_rd,
   input  logic [DATA_W-1:0] fwd_ex_data,
   input  logic              fwd_wb_we,
   input  logic [4:0]        fwd_wb_rd,
   input  logic [DATA_W-1:0] fwd_wb_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic [OP_W-1:0]   out_alu_op,
   output logic [4:0]        out_rd_addr,
   output logic              out_rd_we
);

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [OP_W-1:0]   op;
      logic [4:0]        rd;
      logic              we;
   } entry_t;

   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

   state_t r_state;
   entry_t r_out;
   entry_t r_skid;
   entry_t w_new;
   logic   w_accept;
   logic   w_emit;

   // EX beats WB; index 0 never forwards, so x0 always reads the register file.
   function automatic logic [DATA_W-1:0] resolve(
      input logic [4:0]        rs,
      input logic [DATA_W-1:0] rf,
      input logic              ex_we,
      input logic [4:0]        ex_rd,
      input logic [DATA_W-1:0] ex_data,
      input logic              wb_we,
      input logic [4:0]        wb_rd,
      input logic [DATA_W-1:0] wb_data
   );
      logic [DATA_W-1:0] v;
      v = rf;
      if (rs != 5'd0) begin
         if (ex_we && ex_rd == rs)      v = ex_data;
         else if (wb_we && wb_rd == rs) v = wb_data;
      end
      return v;
   endfunction

   always_comb begin
      w_new    = '0;
      w_new.a  = resolve(in_rs1_addr, in_rs1_data, fwd_ex_we, fwd_ex_rd, fwd_ex_data,
                         fwd_wb_we, fwd_wb_rd, fwd_wb_data);
      w_new.b  = in_use_imm ? in_imm
                            : resolve(in_rs2_addr, in_rs2_data, fwd_ex_we, fwd_ex_rd, fwd_ex_data,
                                      fwd_wb_we, fwd_wb_rd, fwd_wb_data);
      w_new.op = in_alu_op;
      w_new.rd = in_rd_addr;
      w_new.we = in_rd_we;
   end

   // Both handshake outputs decode from registered state only.
   assign in_ready  = (r_state != S_TWO);
   assign out_valid = (r_state != S_EMPTY);
   assign w_accept  = in_valid && in_ready;
   assign w_emit    = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_EMPTY;
         r_out   <= '0;
         r_skid  <= '0;
      end else if (flush) begin
         r_state <= S_EMPTY;
      end else begin
         case (r_state)
            S_EMPTY: if (w_accept) begin
               r_out   <= w_new;
               r_state <= S_ONE;
            end
            S_ONE: begin
               if (w_accept && w_emit) begin
                  r_out <= w_new;
               end else if (w_accept) begin
                  r_skid  <= w_new;
                  r_state <= S_TWO;
               end else if (w_emit) begin
                  r_state <= S_EMPTY;
               end
            end
            S_TWO: if (w_emit) begin
               r_out   <= r_skid;
               r_state <= S_ONE;
            end
            default: r_state <= S_EMPTY;
         endcase
      end
   end

   assign out_a       = r_out.a;
   assign out_b       = r_out.b;
   assign out_alu_op  = r_out.op;
   assign out_rd_addr = r_out.rd;
   assign out_rd_we   = r_out.we;

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: directed scenarios followed by random traffic.
// Every output is compared against a queue-based reference model held in the bench.
module tb_operand_stage;
   localparam int DW = 32;
   localparam int OW = 4;

   logic clk, rst_n;
   logic in_valid, in_ready, in_use_imm, in_rd_we;
   logic [4:0] in_rs1_addr, in_rs2_addr, in_rd_addr;
   logic [DW-1:0] in_rs1_data, in_rs2_data, in_imm;
   logic [OW-1:0] in_alu_op;
   logic fwd_ex_we, fwd_wb_we, flush;
   logic [4:0] fwd_ex_rd, fwd_wb_rd;
   logic [DW-1:0] fwd_ex_data, fwd_wb_data;
   logic out_valid, out_ready, out_rd_we;
   logic [DW-1:0] out_a, out_b;
   logic [OW-1:0] out_alu_op;
   logic [4:0] out_rd_addr;

   operand_stage #(.DATA_W(DW), .OP_W(OW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_imm(in_imm), .in_use_imm(in_use_imm), .in_alu_op(in_alu_op),
      .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we),
      .fwd_ex_we(fwd_ex_we), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
      .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_alu_op(out_alu_op),
      .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [OW-1:0] op;
      logic [4:0]    rd;
      logic          we;
   } exp_t;

   exp_t q[$];
   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [DW-1:0] ref_operand(input logic [4:0] rs, input logic [DW-1:0] rf);
      if (rs == 0) return rf;
      if (fwd_ex_we && fwd_ex_rd == rs) return fwd_ex_data;
      if (fwd_wb_we && fwd_wb_rd == rs) return fwd_wb_data;
      return rf;
   endfunction

   task automatic check_model(input string tag);
      check({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
      check({tag, ".in_ready"}, 64'(in_ready), 64'(q.size() < 2));
      if (q.size() > 0) begin
         check({tag, ".out_a"}, 64'(out_a), 64'(q[0].a));
         check({tag, ".out_b"}, 64'(out_b), 64'(q[0].b));
         check({tag, ".out_alu_op"}, 64'(out_alu_op), 64'(q[0].op));
         check({tag, ".out_rd_addr"}, 64'(out_rd_addr), 64'(q[0].rd));
         check({tag, ".out_rd_we"}, 64'(out_rd_we), 64'(q[0].we));
      end
   endtask

   // One clock: predict from inputs, apply the edge to the model, then compare at negedge.
   task automatic tick(input string tag);
      exp_t e;
      bit acc, emt;
      acc  = in_valid && (q.size() < 2);
      emt  = out_ready && (q.size() > 0);
      e.a  = ref_operand(in_rs1_addr, in_rs1_data);
      e.b  = in_use_imm ? in_imm : ref_operand(in_rs2_addr, in_rs2_data);
      e.op = in_alu_op;
      e.rd = in_rd_addr;
      e.we = in_rd_we;
      @(posedge clk);
      if (flush) q.delete();
      else begin
         if (emt) void'(q.pop_front());
         if (acc) q.push_back(e);
      end
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic set_in(input logic v, input logic [4:0] rs1, input logic [DW-1:0] d1,
                         input logic [4:0] rs2, input logic [DW-1:0] d2,
                         input logic [DW-1:0] imm, input logic ui, input logic [OW-1:0] op);
      in_valid = v; in_rs1_addr = rs1; in_rs1_data = d1; in_rs2_addr = rs2; in_rs2_data = d2;
      in_imm = imm; in_use_imm = ui; in_alu_op = op;
   endtask

   task automatic set_fwd(input logic exw, input logic [4:0] exr, input logic [DW-1:0] exd,
                          input logic wbw, input logic [4:0] wbr, input logic [DW-1:0] wbd);
      fwd_ex_we = exw; fwd_ex_rd = exr; fwd_ex_data = exd;
      fwd_wb_we = wbw; fwd_wb_rd = wbr; fwd_wb_data = wbd;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      in_rd_addr = 5'd0; in_rd_we = 1'b0;
      set_in(1'b0, 5'd0, '0, 5'd0, '0, '0, 1'b0, '0);
      set_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
      repeat (2) @(negedge clk);
      check("rst.out_valid", 64'(out_valid), 64'd0);
      check("rst.in_ready", 64'(in_ready), 64'd1);
      check("rst.out_a", 64'(out_a), 64'd0);
      check("rst.out_b", 64'(out_b), 64'd0);
      check("rst.out_alu_op", 64'(out_alu_op), 64'd0);
      check("rst.out_rd", 64'({out_rd_addr, out_rd_we}), 64'd0);
      rst_n = 1'b1;

      // Basic single-cycle latency
      set_in(1'b1, 5'd1, 32'd1, 5'd2, 32'd1, '0, 1'b0, 4'h0);
      in_rd_addr = 5'd3; in_rd_we = 1'b1;
      tick("basic");
      check("basic.a", 64'(out_a), 64'd1);
      check("basic.b", 64'(out_b), 64'd1);
      check("basic.valid", 64'(out_valid), 64'd1);

      // EX priority over WB, then WB alone
      set_in(1'b1, 5'd5, 32'd9, 5'd0, '0, '0, 1'b0, 4'h1);
      set_fwd(1'b1, 5'd5, 32'd10, 1'b1, 5'd5, 32'd11);
      tick("fwd_ex");
      check("fwd_ex.a", 64'(out_a), 64'd10);
      fwd_ex_we = 1'b0;
      tick("fwd_wb");
      check("fwd_wb.a", 64'(out_a), 64'd11);

      // No forwarding to x0
      set_in(1'b1, 5'd0, 32'd0, 5'd0, 32'd0, '0, 1'b0, 4'h2);
      set_fwd(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
      tick("x0");
      check("x0.a", 64'(out_a), 64'd0);
      set_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
      in_valid = 1'b0;
      tick("drain");

      // Backpressure: two held, third stalls, then in-order drain
      out_ready = 1'b0;
      set_in(1'b1, 5'd1, 32'd5, 5'd0, '0, 32'd3, 1'b1, 4'h0);
      tick("bp1");
      set_in(1'b1, 5'd1, 32'd10, 5'd0, '0, 32'd3, 1'b1, 4'h0);
      tick("bp2");
      check("bp.stall", 64'(in_ready), 64'd0);
      set_in(1'b1, 5'd1, 32'd7, 5'd0, '0, 32'd1, 1'b1, 4'h0);
      tick("bp3");
      check("bp.hold_a", 64'(out_a), 64'd5);
      check("bp.hold_b", 64'(out_b), 64'd3);
      out_ready = 1'b1;
      tick("bp4");
      check("bp.second_a", 64'(out_a), 64'd10);
      tick("bp5");
      check("bp.third_a", 64'(out_a), 64'd7);
      check("bp.third_b", 64'(out_b), 64'd1);
      in_valid = 1'b0;
      tick("bp6");
      check("bp.empty", 64'(out_valid), 64'd0);

      // Flush from TWO with a simultaneous valid input
      out_ready = 1'b0; in_valid = 1'b1;
      tick("fl1");
      tick("fl2");
      flush = 1'b1;
      tick("fl3");
      check("flush.valid", 64'(out_valid), 64'd0);
      check("flush.ready", 64'(in_ready), 64'd1);
      flush = 1'b0;
      tick("fl4");

      // Asynchronous reset while holding an entry
      #2 rst_n = 1'b0;
      #1;
      check("arst.valid", 64'(out_valid), 64'd0);
      check("arst.ready", 64'(in_ready), 64'd1);
      check("arst.a", 64'(out_a), 64'd0);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      set_in(1'b1, 5'd4, 32'h1234, 5'd0, '0, '0, 1'b0, 4'h3);
      tick("post_rst");
      check("post_rst.a", 64'(out_a), 64'h1234);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         set_in($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), $urandom(),
                5'($urandom_range(0, 3)), $urandom(), $urandom(), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)));
         in_rd_addr = 5'($urandom_range(0, 31)); in_rd_we = 1'($urandom_range(0, 1));
         set_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom(),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom());
         out_ready = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 24) == 0);
         tick("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
